// File: rtl/regfile_wb_scheduler.sv
// Register file write-port arbiter (ALU/LSU round-robin) with a
// per-register busy scoreboard that gates instruction issue.
module regfile_wb_scheduler #(
   parameter int RegWidth = 32,
   parameter int RegDepth = 32,
   localparam int AW = $clog2(RegDepth)
) (
   input  logic                clk_i,
   input  logic                rst_ni,
   input  logic                flush_i,
   input  logic                iss_valid_i,
   output logic                iss_ready_o,
   input  logic [AW-1:0]       iss_rs1_addr_i,
   input  logic [AW-1:0]       iss_rs2_addr_i,
   input  logic [AW-1:0]       iss_rd_addr_i,
   input  logic                iss_rd_en_i,
   input  logic                alu_valid_i,
   output logic                alu_ready_o,
   input  logic [AW-1:0]       alu_addr_i,
   input  logic [RegWidth-1:0] alu_data_i,
   input  logic                lsu_valid_i,
   output logic                lsu_ready_o,
   input  logic [AW-1:0]       lsu_addr_i,
   input  logic [RegWidth-1:0] lsu_data_i,
   output logic                rd_wr_en_o,
   output logic [AW-1:0]       rd_addr_o,
   output logic [RegWidth-1:0] rd_data_o,
   output logic [RegDepth-1:0] busy_o
);

   logic [RegDepth-1:0] r_busy;
   logic [RegDepth-1:0] w_busy_nxt;
   logic                r_last_lsu;
   logic                w_gnt_alu;
   logic                w_gnt_lsu;
   logic                w_wb_fire;
   logic                w_iss_fire;
   logic                w_waw;
   logic [AW-1:0]       w_wb_addr;
   logic [RegWidth-1:0] w_wb_data;

   // Grants are forced low while reset is asserted so nothing can fire.
   always_comb begin
      w_gnt_alu = 1'b0;
      w_gnt_lsu = 1'b0;
      if (rst_ni) begin
         if (alu_valid_i && lsu_valid_i) begin
            w_gnt_alu = r_last_lsu;
            w_gnt_lsu = !r_last_lsu;
         end else begin
            w_gnt_alu = alu_valid_i;
            w_gnt_lsu = lsu_valid_i;
         end
      end
   end

   always_comb begin
      w_wb_addr = '0;
      w_wb_data = '0;
      if (w_gnt_alu) begin
         w_wb_addr = alu_addr_i;
         w_wb_data = alu_data_i;
      end else if (w_gnt_lsu) begin
         w_wb_addr = lsu_addr_i;
         w_wb_data = lsu_data_i;
      end
   end

   assign w_wb_fire = w_gnt_alu | w_gnt_lsu;
   assign w_waw     = iss_rd_en_i & r_busy[iss_rd_addr_i];

   assign iss_ready_o = rst_ni & !flush_i
                      & !r_busy[iss_rs1_addr_i]
                      & !r_busy[iss_rs2_addr_i]
                      & !w_waw;

   assign w_iss_fire = iss_valid_i & iss_ready_o;

   // Clear before set so a same-edge issue to the register keeps it busy.
   always_comb begin
      w_busy_nxt = r_busy;
      if (flush_i) begin
         w_busy_nxt = '0;
      end else begin
         if (w_wb_fire) begin
            w_busy_nxt[w_wb_addr] = 1'b0;
         end
         if (w_iss_fire && iss_rd_en_i) begin
            w_busy_nxt[iss_rd_addr_i] = 1'b1;
         end
      end
      w_busy_nxt[0] = 1'b0;
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         r_busy     <= '0;
         r_last_lsu <= 1'b1;
      end else begin
         r_busy <= w_busy_nxt;
         if (w_wb_fire) begin
            r_last_lsu <= w_gnt_lsu;
         end
      end
   end

   assign alu_ready_o = w_gnt_alu;
   assign lsu_ready_o = w_gnt_lsu;
   assign rd_wr_en_o  = w_wb_fire;
   assign rd_addr_o   = w_wb_addr;
   assign rd_data_o   = w_wb_data;
   assign busy_o      = r_busy;

endmodule

// File: tb/tb_regfile_wb_scheduler.sv
// Bench for regfile_wb_scheduler: scoreboard/arbiter model checked every
// cycle, plus directed scenarios with literal expectations.
module tb_regfile_wb_scheduler;

   localparam int W = 32;
   localparam int D = 32;
   localparam int AW = 5;

   logic          clk = 1'b0;
   logic          rst_n = 1'b0;
   logic          flush = 1'b0;
   logic          iss_v = 1'b0;
   logic          iss_r;
   logic [AW-1:0] rs1 = '0;
   logic [AW-1:0] rs2 = '0;
   logic [AW-1:0] rd = '0;
   logic          rd_en = 1'b0;
   logic          alu_v = 1'b0;
   logic          alu_r;
   logic [AW-1:0] alu_a = '0;
   logic [W-1:0]  alu_d = '0;
   logic          lsu_v = 1'b0;
   logic          lsu_r;
   logic [AW-1:0] lsu_a = '0;
   logic [W-1:0]  lsu_d = '0;
   logic          wr_en;
   logic [AW-1:0] wr_a;
   logic [W-1:0]  wr_d;
   logic [D-1:0]  busy;

   int checks = 0;
   int errors = 0;

   regfile_wb_scheduler #(.RegWidth(W), .RegDepth(D)) dut (
      .clk_i(clk), .rst_ni(rst_n), .flush_i(flush),
      .iss_valid_i(iss_v), .iss_ready_o(iss_r),
      .iss_rs1_addr_i(rs1), .iss_rs2_addr_i(rs2),
      .iss_rd_addr_i(rd), .iss_rd_en_i(rd_en),
      .alu_valid_i(alu_v), .alu_ready_o(alu_r),
      .alu_addr_i(alu_a), .alu_data_i(alu_d),
      .lsu_valid_i(lsu_v), .lsu_ready_o(lsu_r),
      .lsu_addr_i(lsu_a), .lsu_data_i(lsu_d),
      .rd_wr_en_o(wr_en), .rd_addr_o(wr_a), .rd_data_o(wr_d),
      .busy_o(busy)
   );

   always #5 clk = ~clk;

   task automatic chk(input string n, input logic [63:0] a,
                      input logic [63:0] e);
      checks++;
      if (a !== e) begin
         errors++;
         $display("FAIL %s act=%0h exp=%0h", n, a, e);
      end
   endtask

   // Model: set of pending destinations plus who won the last writeback.
   bit pend [D];
   bit last_was_lsu = 1'b1;

   function automatic bit pending(input logic [AW-1:0] r);
      return (r != 0) && pend[r];
   endfunction

   always @(negedge clk) begin
      bit e_iss, e_ga, e_gl;
      logic [AW-1:0] e_a;
      logic [W-1:0] e_d;
      logic [D-1:0] e_busy;
      e_busy = '0;
      for (int i = 1; i < D; i++) e_busy[i] = pend[i];
      if (!rst_n) begin
         chk("rst_iss_ready", {63'b0, iss_r}, 64'd0);
         chk("rst_grants", {62'b0, alu_r, lsu_r}, 64'd0);
         chk("rst_wr_en", {63'b0, wr_en}, 64'd0);
         chk("rst_busy", {32'b0, busy}, 64'd0);
         for (int i = 0; i < D; i++) pend[i] = 1'b0;
         last_was_lsu = 1'b1;
      end else begin
         e_iss = !flush && !pending(rs1) && !pending(rs2)
               && !(rd_en && pending(rd));
         if (alu_v && lsu_v) begin
            e_ga = last_was_lsu;
            e_gl = !last_was_lsu;
         end else begin
            e_ga = alu_v;
            e_gl = lsu_v;
         end
         e_a = e_ga ? alu_a : (e_gl ? lsu_a : '0);
         e_d = e_ga ? alu_d : (e_gl ? lsu_d : '0);
         chk("m_iss_ready", {63'b0, iss_r}, {63'b0, e_iss});
         chk("m_grants", {62'b0, alu_r, lsu_r}, {62'b0, e_ga, e_gl});
         chk("m_wr_en", {63'b0, wr_en}, {63'b0, (e_ga | e_gl)});
         chk("m_wr_addr", {59'b0, wr_a}, {59'b0, e_a});
         chk("m_wr_data", {32'b0, wr_d}, {32'b0, e_d});
         chk("m_busy", {32'b0, busy}, {32'b0, e_busy});
         if (flush) begin
            for (int i = 0; i < D; i++) pend[i] = 1'b0;
         end else begin
            if (e_ga || e_gl) pend[e_a] = 1'b0;
            if (iss_v && e_iss && rd_en && rd != 0) pend[rd] = 1'b1;
         end
         if (e_ga || e_gl) last_was_lsu = e_gl;
      end
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic idle();
      iss_v = 0; rd_en = 0; rs1 = 0; rs2 = 0; rd = 0;
      alu_v = 0; lsu_v = 0; flush = 0;
   endtask

   initial begin
      #2;
      chk("t1_reset_busy", {32'b0, busy}, 64'd0);
      chk("t1_reset_ready", {63'b0, iss_r}, 64'd0);
      step(); step();
      rst_n = 1;

      // 1: issue rd=5, then a dependent on x5 stalls
      step();
      iss_v = 1; rd = 5; rd_en = 1;
      #1 chk("t1_issue_ready", {63'b0, iss_r}, 64'd1);
      step();
      chk("t1_busy5", {32'b0, busy}, 64'h20);
      rd_en = 0; rd = 0; rs1 = 5;
      #1 chk("t1_raw_stall", {63'b0, iss_r}, 64'd0);

      // 2: ALU writeback wakes x5 on the following cycle only
      step();
      alu_v = 1; alu_a = 5; alu_d = 32'hDEADBEEF;
      #1;
      chk("t2_wr_en", {63'b0, wr_en}, 64'd1);
      chk("t2_wr_addr", {59'b0, wr_a}, 64'd5);
      chk("t2_wr_data", {32'b0, wr_d}, 64'hDEADBEEF);
      chk("t2_no_bypass", {63'b0, iss_r}, 64'd0);
      step();
      alu_v = 0;
      #1;
      chk("t2_busy_clr", {32'b0, busy}, 64'd0);
      chk("t2_dep_ready", {63'b0, iss_r}, 64'd1);

      // 3: LSU solo first so LSU is last winner, then 3-cycle collision
      step();
      idle();
      lsu_v = 1; lsu_a = 9; lsu_d = 32'h99;
      step();
      alu_v = 1; alu_a = 1; alu_d = 32'h11;
      lsu_a = 2; lsu_d = 32'h22;
      #1 chk("t3_g0", {62'b0, alu_r, lsu_r}, 64'b10);
      step();
      #1 chk("t3_g1", {62'b0, alu_r, lsu_r}, 64'b01);
      step();
      #1 chk("t3_g2", {62'b0, alu_r, lsu_r}, 64'b10);

      // 4: x0 as destination and writeback target
      step();
      idle();
      iss_v = 1; rd_en = 1;
      #1 chk("t4_x0_ready", {63'b0, iss_r}, 64'd1);
      step();
      idle();
      lsu_v = 1; lsu_a = 0; lsu_d = 32'h5A5A;
      #1;
      chk("t4_busy_x0", {32'b0, busy}, 64'd0);
      chk("t4_wr_en_x0", {63'b0, wr_en}, 64'd1);
      step();
      idle();
      #1 chk("t4_busy_after", {32'b0, busy}, 64'd0);

      // 5: mark 3,4,7 busy, then flush alongside issue and LSU wb
      iss_v = 1; rd_en = 1; rd = 3;
      step(); rd = 4;
      step(); rd = 7;
      step();
      idle();
      #1 chk("t5_busy", {32'b0, busy}, 64'h98);
      flush = 1; iss_v = 1; rd_en = 1; rd = 8;
      lsu_v = 1; lsu_a = 3; lsu_d = 32'h33;
      #1;
      chk("t5_iss_blocked", {63'b0, iss_r}, 64'd0);
      chk("t5_lsu_ready", {63'b0, lsu_r}, 64'd1);
      step();
      idle();
      #1 chk("t5_busy_flushed", {32'b0, busy}, 64'd0);

      // 6: ALU wins once, then reset lands mid-collision
      alu_v = 1; lsu_v = 1; alu_a = 1; lsu_a = 2;
      #1 chk("t6_pre_alu", {62'b0, alu_r, lsu_r}, 64'b10);
      step();
      #1 chk("t6_pre_lsu", {62'b0, alu_r, lsu_r}, 64'b01);
      rst_n = 0;
      #1 chk("t6_rst_ready", {62'b0, alu_r, lsu_r}, 64'd0);
      step();
      @(negedge clk);
      #2 rst_n = 1;
      #1 chk("t6_alu_first", {62'b0, alu_r, lsu_r}, 64'b10);
      step();
      idle();
      step(); step();

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
